// File: rtl/rv_dmem_responder_if.sv
// ---------------------------------------------------------------------------
// rv_dmem_responder_if
// Load/store bus between the uRV execute/writeback stages and the data-memory
// responder.
//
// Signals:
//   dm_addr         32  byte address
//   dm_data_s       32  store data (already lane-replicated by the core)
//   dm_data_select   4  byte-lane enables for stores
//   dm_store         1  store request, held until dm_ready
//   dm_load          1  load request, held until dm_ready
//   dm_ready         1  access accepted this cycle
//   dm_data_l       32  load data, valid the cycle after a load is accepted
//   dm_error         1  out-of-range access (only with URV_DMEM_ERROR_EN)
//
// Modports: master (core side), slave (responder side).
// ---------------------------------------------------------------------------
interface rv_dmem_responder_if;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_s;
    logic [3:0]  dm_data_select;
    logic        dm_store;
    logic        dm_load;
    logic        dm_ready;
    logic [31:0] dm_data_l;
`ifdef URV_DMEM_ERROR_EN
    logic        dm_error;
`endif

    modport master (
        output dm_addr,
        output dm_data_s,
        output dm_data_select,
        output dm_store,
        output dm_load,
        input  dm_ready,
`ifdef URV_DMEM_ERROR_EN
        input  dm_error,
`endif
        input  dm_data_l
    );

    modport slave (
        input  dm_addr,
        input  dm_data_s,
        input  dm_data_select,
        input  dm_store,
        input  dm_load,
        output dm_ready,
`ifdef URV_DMEM_ERROR_EN
        output dm_error,
`endif
        output dm_data_l
    );
endinterface

// File: rtl/rv_dmem_responder.sv
// ---------------------------------------------------------------------------
// rv_dmem_responder
// Data-memory responder for the uRV core. Accepts one load or store per
// handshake, stretches it by WAIT_STATES cycles by holding dm_ready low,
// performs byte-lane-masked writes into a local word RAM and registers load
// data one cycle after acceptance.
//
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset
//   dm     rv_dmem_responder_if.slave load/store bus
//
// Parameters:
//   ADDR_WIDTH   word-address bits (RAM is 2^ADDR_WIDTH x 32)
//   WAIT_STATES  wait cycles before dm_ready (0..15)
//   BASE_ADDR    byte base address, aligned to 2^(ADDR_WIDTH+2)
//
// Optional feature macro: URV_DMEM_ERROR_EN
//   defined   : out-of-range accesses are acknowledged with dm_error, stores
//               are dropped and loads return zero
//   undefined : upper address bits ignored, RAM aliases everywhere
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | no access in progress
// S_WAIT | wait-state down-counter wcnt running
// ---------------------------------------------------------------------------
module rv_dmem_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    rv_dmem_responder_if.slave  dm
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WCNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q, wcnt_d;
    logic [31:0]             data_l_q;
    logic [31:0]             mem_q [0:DEPTH-1];

    logic                    req;
    logic                    ready;
    logic                    in_range;
    logic                    wr_en;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   word_idx;

    assign req      = dm.dm_load | dm.dm_store;
    assign word_idx = dm.dm_addr[ADDR_WIDTH+1:2];

`ifdef URV_DMEM_ERROR_EN
    logic unused_bits;
    assign in_range    = (dm.dm_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign dm.dm_error = ready & ~in_range;
    assign unused_bits = ^{dm.dm_addr[1:0], BASE_ADDR[ADDR_WIDTH+1:0]};
`else
    logic unused_bits;
    assign in_range    = 1'b1;
    assign unused_bits = ^{dm.dm_addr[31:ADDR_WIDTH+2], dm.dm_addr[1:0], BASE_ADDR};
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        ready = 1'b1;
                    end else begin
                        wcnt_d  = WCNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    // Core withdrew the request: drop it without side effects.
                    wcnt_d  = 4'd0;
                    state_d = S_IDLE;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    ready   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                wcnt_d  = 4'd0;
            end
        endcase
        // Reset must never acknowledge, so no write can slip through.
        if (rst_i) begin
            ready = 1'b0;
        end
    end

    assign dm.dm_ready = ready;

    // Store wins when both requests are raised together.
    assign wr_en = ready & dm.dm_store & in_range;
    assign rd_en = ready & dm.dm_load & ~dm.dm_store;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (dm.dm_data_select[n]) begin
                    mem_q[word_idx][8*n +: 8] <= dm.dm_data_s[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_l_q <= 32'h0;
        end else if (rd_en) begin
            data_l_q <= in_range ? mem_q[word_idx] : 32'h0;
        end
    end

    assign dm.dm_data_l = data_l_q;

endmodule

// File: tb/tb_rv_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_rv_dmem_responder
// Two responders: index 0 with WAIT_STATES=0, index 1 with WAIT_STATES=3.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge or 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rv_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] a_addr [2];
    logic [31:0] a_wdat [2];
    logic [3:0]  a_sel  [2];
    logic        a_st   [2];
    logic        a_ld   [2];
    logic        rdy    [2];
    logic [31:0] dl     [2];
    logic        errv   [2];

    rv_dmem_responder_if if0 ();
    rv_dmem_responder_if if3 ();

    assign if0.dm_addr        = a_addr[0];
    assign if0.dm_data_s      = a_wdat[0];
    assign if0.dm_data_select = a_sel[0];
    assign if0.dm_store       = a_st[0];
    assign if0.dm_load        = a_ld[0];
    assign rdy[0]             = if0.dm_ready;
    assign dl[0]              = if0.dm_data_l;

    assign if3.dm_addr        = a_addr[1];
    assign if3.dm_data_s      = a_wdat[1];
    assign if3.dm_data_select = a_sel[1];
    assign if3.dm_store       = a_st[1];
    assign if3.dm_load        = a_ld[1];
    assign rdy[1]             = if3.dm_ready;
    assign dl[1]              = if3.dm_data_l;

`ifdef URV_DMEM_ERROR_EN
    assign errv[0] = if0.dm_error;
    assign errv[1] = if3.dm_error;
`else
    assign errv[0] = 1'b0;
    assign errv[1] = 1'b0;
`endif

    rv_dmem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .dm    (if0)
    );

    rv_dmem_responder #(.ADDR_WIDTH(12), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .dm    (if3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called 1 unit after a rising edge. Returns 1 unit after the edge that
    // follows acceptance, with the request dropped and load data sampled.
    task automatic access(input int d, input logic st, input logic ld,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [3:0] sel, output int lat,
                          output logic [31:0] rdata, output logic err,
                          output longint t_acc);
        a_addr[d] = addr;
        a_wdat[d] = wdat;
        a_sel[d]  = sel;
        a_st[d]   = st;
        a_ld[d]   = ld;
        lat   = -1;
        err   = 1'b0;
        t_acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                lat   = c;
                err   = errv[d];
                t_acc = longint'($time);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        a_st[d] = 1'b0;
        a_ld[d] = 1'b0;
        rdata   = dl[d];
    endtask

    typedef struct {
        logic        st;
        logic        ld;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic [31:0] exp_dl;
    } vec_t;

    logic [31:0] mdl    [2][16];
    logic [31:0] mdl_dl [2];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [11];
        int          lat;
        logic [31:0] rdata;
        logic        err;
        longint      t_acc, t_prev;
        int          lowcnt;

        vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h10, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h20, 32'h11223344, 4'b1111, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'h20, 32'hAAAAAAAA, 4'b0100, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h20, 32'h0,        4'b0000, 32'h11AA3344};
        vecs[5]  = '{1'b1, 1'b0, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h11AA3344};
        vecs[6]  = '{1'b0, 1'b1, 32'h13, 32'h0,        4'b0000, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 1'b1, 32'h20, 32'h00000055, 4'b0001, 32'hDEADBEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'h20, 32'h0,        4'b0000, 32'h11AA3355};
        vecs[9]  = '{1'b1, 1'b0, 32'h10, 32'h12345678, 4'b1010, 32'h11AA3355};
        vecs[10] = '{1'b0, 1'b1, 32'h10, 32'h0,        4'b0000, 32'h12AD56EF};

        for (int d = 0; d < 2; d++) begin
            a_addr[d] = 32'h0;
            a_wdat[d] = 32'h0;
            a_sel[d]  = 4'h0;
            a_st[d]   = 1'b0;
            a_ld[d]   = 1'b1;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready0", {31'b0, rdy[0]}, 32'h0);
        check("reset_ready3", {31'b0, rdy[1]}, 32'h0);
        check("reset_dl0", dl[0], 32'h0);
        check("reset_dl3", dl[1], 32'h0);
        check("reset_err0", {31'b0, errv[0]}, 32'h0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        a_ld[0] = 1'b0;
        a_ld[1] = 1'b0;

        // ---- table: WAIT_STATES=0, back-to-back ----
        t_prev = 0;
        for (int i = 0; i < 11; i++) begin
            access(0, vecs[i].st, vecs[i].ld, vecs[i].addr, vecs[i].wdat, vecs[i].sel,
                   lat, rdata, err, t_acc);
            check($sformatf("tbl%0d_lat", i), 32'(lat), 32'd0);
            check($sformatf("tbl%0d_dl", i), rdata, vecs[i].exp_dl);
            if (i > 0) check($sformatf("tbl%0d_gap", i), 32'(t_acc - t_prev), 32'd10);
            t_prev = t_acc;
        end

`ifdef URV_DMEM_ERROR_EN
        access(0, 1'b1, 1'b0, 32'h0, 32'hCAFEF00D, 4'hF, lat, rdata, err, t_acc);
        check("err_inrange_flag", {31'b0, err}, 32'h0);
        access(0, 1'b1, 1'b0, 32'h4000, 32'h99999999, 4'hF, lat, rdata, err, t_acc);
        check("err_store_lat", 32'(lat), 32'd0);
        check("err_store_flag", {31'b0, err}, 32'h1);
        access(0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, lat, rdata, err, t_acc);
        check("err_word0_kept", rdata, 32'hCAFEF00D);
        access(0, 1'b0, 1'b1, 32'h4000, 32'h0, 4'h0, lat, rdata, err, t_acc);
        check("err_load_flag", {31'b0, err}, 32'h1);
        check("err_load_zero", rdata, 32'h0);
`else
        access(0, 1'b0, 1'b1, 32'h12340010, 32'h0, 4'h0, lat, rdata, err, t_acc);
        check("alias_load", rdata, 32'h12AD56EF);
`endif

        // ---- WAIT_STATES=3 ----
        access(1, 1'b1, 1'b0, 32'h40, 32'h0BADF00D, 4'hF, lat, rdata, err, t_acc);
        check("ws3_store_lat", 32'(lat), 32'd3);
        t_prev = 0;
        for (int i = 0; i < 3; i++) begin
            access(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, lat, rdata, err, t_acc);
            check($sformatf("ws3_load%0d_lat", i), 32'(lat), 32'd3);
            check($sformatf("ws3_load%0d_dl", i), rdata, 32'h0BADF00D);
            if (i > 0) check($sformatf("ws3_load%0d_gap", i), 32'(t_acc - t_prev), 32'd40);
            t_prev = t_acc;
        end

        // kill a store after one cycle
        a_addr[1] = 32'h40;
        a_wdat[1] = 32'hFFFFFFFF;
        a_sel[1]  = 4'hF;
        a_st[1]   = 1'b1;
        lowcnt = 0;
        @(negedge clk);
        if (rdy[1] !== 1'b0) lowcnt++;
        @(posedge clk);
        #1;
        a_st[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0) lowcnt++;
        end
        check("kill_no_ready", 32'(lowcnt), 32'd0);
        @(posedge clk);
        #1;
        access(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, lat, rdata, err, t_acc);
        check("kill_load_lat", 32'(lat), 32'd3);
        check("kill_ram_kept", rdata, 32'h0BADF00D);

        // reset during WAIT
        a_addr[1] = 32'h40;
        a_wdat[1] = 32'h12121212;
        a_sel[1]  = 4'hF;
        a_st[1]   = 1'b1;
        lowcnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0) lowcnt++;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        if (rdy[1] !== 1'b0) lowcnt++;
        check("rstwait_no_ready", 32'(lowcnt), 32'd0);
        @(posedge clk);
        #1;
        check("rstwait_dl", dl[1], 32'h0);
        rst     = 1'b0;
        a_st[1] = 1'b0;
        access(1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, lat, rdata, err, t_acc);
        check("rstwait_full_lat", 32'(lat), 32'd3);
        check("rstwait_ram_kept", rdata, 32'h0BADF00D);

        // ---- randomized, both DUTs, against a word/byte model ----
        for (int d = 0; d < 2; d++) begin
            int ws;
            ws = (d == 0) ? 0 : 3;
            for (int w = 0; w < 16; w++) begin
                logic [31:0] v;
                v = $urandom;
                mdl[d][w] = v;
                access(d, 1'b1, 1'b0, 32'(w) << 2, v, 4'hF, lat, rdata, err, t_acc);
                check($sformatf("rnd%0d_init%0d_lat", d, w), 32'(lat), 32'(ws));
            end
            access(d, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, lat, rdata, err, t_acc);
            mdl_dl[d] = mdl[d][0];
            check($sformatf("rnd%0d_init_dl", d), rdata, mdl_dl[d]);
            for (int k = 0; k < 60; k++) begin
                int          op;
                int          w;
                logic [3:0]  sel;
                logic [31:0] v;
                logic [31:0] addr;
                logic [31:0] hi;
                logic        st, ld;
                op  = $urandom_range(0, 2);
                w   = $urandom_range(0, 15);
                sel = 4'($urandom_range(0, 15));
                v   = $urandom;
`ifdef URV_DMEM_ERROR_EN
                hi = 32'h0;
`else
                hi = 32'($urandom_range(0, 32'h3FFFF));
`endif
                addr = (hi << 14) | (32'(w) << 2) | 32'($urandom_range(0, 3));
                st = (op != 1);
                ld = (op != 0);
                access(d, st, ld, addr, v, sel, lat, rdata, err, t_acc);
                if (st) begin
                    for (int n = 0; n < 4; n++)
                        if (sel[n]) mdl[d][w][8*n +: 8] = v[8*n +: 8];
                end else begin
                    mdl_dl[d] = mdl[d][w];
                end
                check($sformatf("rnd%0d_%0d_lat", d, k), 32'(lat), 32'(ws));
                check($sformatf("rnd%0d_%0d_dl", d, k), rdata, mdl_dl[d]);
                check($sformatf("rnd%0d_%0d_err", d, k), {31'b0, err}, 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
